// File: rtl/aes_key_schedule_rev.sv
// AES-128 reverse key schedule.
// The cipher key is expanded forward to the last round key. The round keys
// are then produced from round NR down to round 0, one per transfer.
//
// Handshake: rk_valid/rk_ready. A transfer happens on a rising edge where
// both are high. While rk_valid is high and rk_ready is low, rk, rk_round
// and rk_last hold their values. rk_valid never drops until the round-0
// key has been transferred.
//
// One g-function datapath serves both directions. In EXPAND it computes
// g(w3, cnt+1) for the forward step. In EMIT it computes g(w3^w2, cnt) for
// the reverse step. The FSM state is held in the 'state' register so that
// checkers can bind to it.
module aes_key_schedule_rev #(
  parameter int NR          = 10,
  parameter bit SKIP_EXPAND = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
);

  localparam logic [3:0] CNT_LAST = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t       state;
  logic [127:0] key_q;
  logic [3:0]   cnt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  g_in;
  logic [3:0]   g_idx;
  logic [31:0]  g_out;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] fwd_key;
  logic [127:0] rev_key;

  // ---------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // Multiplicative inverse as a^254; the chain maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_sq(a);
    x3   = gf_mul(x2, a);
    x6   = gf_sq(x3);
    x12  = gf_sq(x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_sq(x15);
    x60  = gf_sq(x30);
    x120 = gf_sq(x60);
    x240 = gf_sq(x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // Shared S-box: encrypt=1 gives SubBytes and encrypt=0 gives InvSubBytes.
  // The key schedule only uses encrypt=1 in both directions.
  function automatic logic [7:0] bsbox(input logic [7:0] x, input logic encrypt);
    logic [7:0] a;
    if (encrypt) begin
      a = gf_inv(x);
      return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    end else begin
      a = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      return gf_inv(a);
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {bsbox(w[31:24], 1'b1), bsbox(w[23:16], 1'b1),
            bsbox(w[15:8],  1'b1), bsbox(w[7:0],   1'b1)};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Shared g-function plus the forward and reverse next-key candidates.
  always_comb begin
    w0      = key_q[127:96];
    w1      = key_q[95:64];
    w2      = key_q[63:32];
    w3      = key_q[31:0];
    g_in    = (state == EMIT) ? (w3 ^ w2) : w3;
    g_idx   = (state == EMIT) ? cnt : (cnt + 4'd1);
    g_out   = sub_word(rot_word(g_in)) ^ {rcon(g_idx), 24'h000000};
    f0      = w0 ^ g_out;
    f1      = w1 ^ f0;
    f2      = w2 ^ f1;
    f3      = w3 ^ f2;
    fwd_key = {f0, f1, f2, f3};
    rev_key = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  // Control FSM, key register, round counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      key_q    <= '0;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= key_in;
            busy  <= 1'b1;
            if (SKIP_EXPAND) begin
              cnt      <= CNT_LAST;
              state    <= EMIT;
              rk_valid <= 1'b1;
              rk_last  <= (CNT_LAST == 4'd0);
            end else begin
              cnt   <= 4'd0;
              state <= EXPAND;
            end
          end
        end
        EXPAND: begin
          key_q <= fwd_key;
          cnt   <= cnt + 4'd1;
          if ((cnt + 4'd1) == CNT_LAST) begin
            state    <= EMIT;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (cnt != 4'd0) begin
              key_q   <= rev_key;
              cnt     <= cnt - 4'd1;
              rk_last <= (cnt == 4'd1);
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rk       = key_q;
  assign rk_round = cnt;

endmodule

// File: tb/tb_aes_key_schedule_rev.sv
// Directed bench for aes_key_schedule_rev: FIPS-197 A.1 round keys in reverse
// order, backpressure, SKIP_EXPAND, ignored starts and asynchronous reset.
module tb_aes_key_schedule_rev;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         start_f, start_s;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         busy_f, valid_f, last_f, done_f;
  logic         busy_s, valid_s, last_s, done_s;
  logic [127:0] rk_f, rk_s;
  logic [3:0]   round_f, round_s;

  logic         sel;
  logic         cur_busy, cur_valid, cur_last, cur_done;
  logic [127:0] cur_rk;
  logic [3:0]   cur_round;

  aes_key_schedule_rev #(.NR(10), .SKIP_EXPAND(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start_f), .key_in(key_in), .busy(busy_f),
    .rk_valid(valid_f), .rk_ready(rk_ready), .rk(rk_f), .rk_round(round_f),
    .rk_last(last_f), .done(done_f)
  );

  aes_key_schedule_rev #(.NR(10), .SKIP_EXPAND(1'b1)) dut_skip (
    .clk(clk), .rst(rst), .start(start_s), .key_in(key_in), .busy(busy_s),
    .rk_valid(valid_s), .rk_ready(rk_ready), .rk(rk_s), .rk_round(round_s),
    .rk_last(last_s), .done(done_s)
  );

  always_comb begin
    cur_busy  = sel ? busy_s  : busy_f;
    cur_valid = sel ? valid_s : valid_f;
    cur_last  = sel ? last_s  : last_f;
    cur_done  = sel ? done_s  : done_f;
    cur_rk    = sel ? rk_s    : rk_f;
    cur_round = sel ? round_s : round_f;
  end

  // ---------------- expected values ----------------
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc;
  logic found;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_fips_exp();
    exp_q.delete();
    for (int i = 10; i >= 0; i--) exp_q.push_back(FIPS_RK[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_start(input logic v);
    if (sel) start_s = v;
    else     start_f = v;
  endtask

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    set_start(1'b1);
    @(posedge clk);
    #1;
    start_f = 1'b0;
    start_s = 1'b0;
  endtask

  // Consume round keys against exp_q. bp: random ready with forced 5-cycle
  // stalls. poke: start pulses during EXPAND, EMIT and the final handshake.
  task automatic collect(input int bp, input int exp_lat, input int poke);
    int lat, c, n_xfer, stall, stalled_for;
    logic seen;
    logic [3:0] er;
    lat = 0; c = 0; n_xfer = 0; stall = 0; stalled_for = -1;
    seen = 1'b0; er = 4'd10;
    rk_ready = 1'b0;
    while (exp_q.size() > 0 && c < 400) begin
      @(negedge clk);
      c++;
      set_start((poke != 0) && (c == 4 || c == 16));
      if (poke != 0 && c == 4) key_in = '1;
      if (!cur_valid) begin
        rk_ready = 1'b0;
        if (seen) check("valid_dropped", 128'(cur_valid), 128'(1));
        else begin
          lat++;
          check("busy_expand", 128'(cur_busy), 128'(1));
        end
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 128'(lat), 128'(exp_lat));
        end
        check("rk", cur_rk, exp_q[0]);
        check("rk_round", 128'(cur_round), 128'(er));
        check("rk_last", 128'(cur_last), 128'(er == 4'd0));
        check("busy_emit", 128'(cur_busy), 128'(1));
        if (bp != 0 && (n_xfer == 3 || n_xfer == 7) && stalled_for != n_xfer) begin
          stalled_for = n_xfer;
          stall = 5;
        end
        if (stall > 0) begin
          rk_ready = 1'b0;
          stall--;
        end else begin
          rk_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rk_ready) begin
          void'(exp_q.pop_front());
          n_xfer++;
          if (er != 4'd0) er--;
          if (poke != 0 && exp_q.size() == 0) set_start(1'b1);
        end
      end
    end
    check("transfers", 128'(n_xfer), 128'(11));
    @(negedge clk);
    set_start(1'b0);
    rk_ready = 1'b0;
    check("done_pulse", 128'(cur_done), 128'(1));
    check("busy_after", 128'(cur_busy), 128'(0));
    check("valid_after", 128'(cur_valid), 128'(0));
    @(negedge clk);
    check("done_once", 128'(cur_done), 128'(0));
    check("busy_idle", 128'(cur_busy), 128'(0));
    check("valid_idle", 128'(cur_valid), 128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start_f = 1'b0; start_s = 1'b0; key_in = '0; rk_ready = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 128'(valid_f), 128'(0));
    check("reset_busy", 128'(busy_f), 128'(0));
    check("reset_rk", rk_f, 128'(0));
    check("reset_round", 128'(round_f), 128'(0));
    check("reset_last_done", 128'({last_f, done_f}), 128'(0));
    check("reset_skip_valid", 128'(valid_s), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", 128'(valid_f), 128'(0));

    // FIPS-197 A.1, full expansion, ready held high
    sel = 1'b0;
    load_fips_exp();
    do_start(FIPS_KEY);
    collect(0, 10, 0);

    // Same key with random backpressure and 5-cycle stalls
    load_fips_exp();
    do_start(FIPS_KEY);
    collect(1, 10, 0);

    // Start pulses while busy and on the final handshake are ignored
    load_fips_exp();
    do_start(FIPS_KEY);
    collect(0, 10, 1);

    // SKIP_EXPAND instance loaded with round key 10
    sel = 1'b1;
    load_fips_exp();
    do_start(FIPS_RK[10]);
    collect(0, 0, 0);
    load_fips_exp();
    do_start(FIPS_RK[10]);
    collect(1, 0, 0);

    // Reset in the middle of EMIT
    sel = 1'b0;
    do_start(FIPS_KEY);
    rk_ready = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cur_valid && cur_round == 4'd6) found = 1'b1;
    end
    check("reach_round6", 128'(found), 128'(1));
    check("round6_rk", cur_rk, FIPS_RK[6]);
    rst = 1'b1;
    #1;
    check("arst_valid", 128'(cur_valid), 128'(0));
    check("arst_busy", 128'(cur_busy), 128'(0));
    check("arst_rk", cur_rk, 128'(0));
    check("arst_round", 128'(cur_round), 128'(0));
    check("arst_last_done", 128'({cur_last, cur_done}), 128'(0));
    rk_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 128'(cur_done), 128'(0));

    // Fresh run with the second key
    do_start(KEY2);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cur_valid) found = 1'b1;
    end
    check("key2_latency", 128'(cyc - 1), 128'(10));
    check("key2_r10", cur_rk, KEY2_R10);
    check("key2_round10", 128'(cur_round), 128'(10));
    rk_ready = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cur_valid && cur_last) found = 1'b1;
    end
    check("key2_reach_last", 128'(found), 128'(1));
    check("key2_r0", cur_rk, KEY2);
    check("key2_round0", 128'(cur_round), 128'(0));
    @(negedge clk);
    rk_ready = 1'b0;
    check("key2_done", 128'(cur_done), 128'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
